// File: rtl/watch_pkg.sv
// Shared constants and state encoding for the stopwatch run/stop/lap/clear sequencer.
package watch_pkg;

  localparam int BCD_W = 24;
  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_NONE = 4'hF;
  localparam logic [CMD_W-1:0] CMD_SS   = 4'hA;
  localparam logic [CMD_W-1:0] CMD_LAP  = 4'hB;
  localparam logic [CMD_W-1:0] CMD_CLR  = 4'hC;

  localparam logic [BCD_W-1:0] MAX_COUNT = 24'h595999;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_FULL  = 3'd4
  } state_t;

endpackage

// File: rtl/watch_ctrl_if.sv
// Bundle between the sequencer, the keyboard scanner, the counter chain and the display.
interface watch_ctrl_if;
  import watch_pkg::*;

  logic [CMD_W-1:0] Command;
  logic [BCD_W-1:0] count_bcd;
  logic             cnt_en;
  logic             cnt_clr;
  logic [BCD_W-1:0] dispbuf;
  logic [2:0]       state;

  modport slave (
    input  Command,
    input  count_bcd,
    output cnt_en,
    output cnt_clr,
    output dispbuf,
    output state
  );

  modport master (
    output Command,
    output count_bcd,
    input  cnt_en,
    input  cnt_clr,
    input  dispbuf,
    input  state
  );

endinterface

// File: rtl/cmd_press_det.sv
// Brings the asynchronous keyboard code into the clk_1Khz domain and flags each new key-down.
module cmd_press_det
  import watch_pkg::*;
#(
  parameter logic [3:0] CMD_NONE = watch_pkg::CMD_NONE
) (
  input  logic             clk_1Khz,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] cmd_async,
  output logic             press,
  output logic [CMD_W-1:0] code
);

  logic [CMD_W-1:0] sync1;
  logic [CMD_W-1:0] sync2;
  logic [CMD_W-1:0] prev;

  // Two-stage synchronizer plus a history stage so a key-down is seen exactly once
  always_ff @(posedge clk_1Khz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= CMD_NONE;
      sync2 <= CMD_NONE;
      prev  <= CMD_NONE;
    end else begin
      sync1 <= cmd_async;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // A press needs the key to pass through "no key"; code-to-code slides are not presses
  always_comb begin
    press = (prev == CMD_NONE) && (sync2 != CMD_NONE);
    code  = sync2;
  end

endmodule

// File: rtl/watch_ctrl.sv
// Stopwatch sequencer: decodes key presses into counter enable/clear and picks live or lap display.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter logic [3:0]  CMD_NONE  = watch_pkg::CMD_NONE,
  parameter logic [3:0]  CMD_SS    = watch_pkg::CMD_SS,
  parameter logic [3:0]  CMD_LAP   = watch_pkg::CMD_LAP,
  parameter logic [3:0]  CMD_CLR   = watch_pkg::CMD_CLR,
  parameter logic [23:0] MAX_COUNT = watch_pkg::MAX_COUNT
) (
  input  logic         clk_1Khz,
  input  logic         rst_n,
  watch_ctrl_if.slave  bus
);

  logic             press;
  logic [CMD_W-1:0] code;
  logic             key_ss;
  logic             key_lap;
  logic             key_clr;
  logic             overflow;

  state_t           state_q;
  state_t           state_d;
  logic             clr_d;
  logic             lap_cap;
  logic             en_d;
  logic [BCD_W-1:0] lap_reg;
  logic [BCD_W-1:0] lap_d;
  logic [BCD_W-1:0] disp_d;

  cmd_press_det #(
    .CMD_NONE (CMD_NONE)
  ) u_press_det (
    .clk_1Khz  (clk_1Khz),
    .rst_n     (rst_n),
    .cmd_async (bus.Command),
    .press     (press),
    .code      (code)
  );

  assign key_ss   = press && (code == CMD_SS);
  assign key_lap  = press && (code == CMD_LAP);
  assign key_clr  = press && (code == CMD_CLR);
  assign overflow = (bus.count_bcd == MAX_COUNT);

  // State register
  always_ff @(posedge clk_1Khz or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Transition rules; overflow outranks any key seen on the same edge
  always_comb begin
    state_d = ST_IDLE;
    clr_d   = 1'b0;
    lap_cap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
        if (key_ss) state_d = ST_RUN;
        else if (key_clr) clr_d = 1'b1;
      end
      ST_RUN: begin
        state_d = ST_RUN;
        if (overflow) state_d = ST_FULL;
        else if (key_ss) state_d = ST_PAUSE;
        else if (key_lap) begin
          state_d = ST_LAP;
          lap_cap = 1'b1;
        end
      end
      ST_LAP: begin
        state_d = ST_LAP;
        if (overflow) state_d = ST_FULL;
        else if (key_lap) lap_cap = 1'b1;
        else if (key_ss) state_d = ST_PAUSE;
        else if (key_clr) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        state_d = ST_PAUSE;
        if (key_ss) state_d = ST_RUN;
        else if (key_clr) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      ST_FULL: begin
        state_d = ST_FULL;
        if (key_clr) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next output values derived from the state being entered, so outputs register alongside state
  always_comb begin
    lap_d = lap_cap ? bus.count_bcd : lap_reg;
    en_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
    case (state_d)
      ST_LAP:  disp_d = lap_d;
      ST_FULL: disp_d = MAX_COUNT;
      default: disp_d = bus.count_bcd;
    endcase
  end

  // Output and lap registers; reset clears everything without emitting a clear pulse
  always_ff @(posedge clk_1Khz or negedge rst_n) begin
    if (!rst_n) begin
      bus.cnt_en  <= 1'b0;
      bus.cnt_clr <= 1'b0;
      bus.dispbuf <= '0;
      lap_reg     <= '0;
    end else begin
      bus.cnt_en  <= en_d;
      bus.cnt_clr <= clr_d;
      bus.dispbuf <= disp_d;
      lap_reg     <= lap_d;
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_watch_ctrl.sv
// Directed scoreboard bench for watch_ctrl: stimulus pushes expected outputs, a monitor pops and compares.
module tb_watch_ctrl;

  localparam logic [3:0]  K_NONE = 4'hF;
  localparam logic [3:0]  K_SS   = 4'hA;
  localparam logic [3:0]  K_LAP  = 4'hB;
  localparam logic [3:0]  K_CLR  = 4'hC;
  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_RUN   = 3'd1;
  localparam logic [2:0]  S_PAUSE = 3'd2;
  localparam logic [2:0]  S_LAP   = 3'd3;
  localparam logic [2:0]  S_FULL  = 3'd4;
  localparam logic [23:0] FULL_VAL = 24'h595999;

  logic clk = 1'b0;
  logic rst_n;

  watch_ctrl_if bus();

  watch_ctrl dut (
    .clk_1Khz (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic        en;
    logic        clr;
    logic [23:0] disp;
  } exp_t;

  exp_t exp_q[$];

  int    total = 0;
  int    bad   = 0;
  int    step  = 0;
  string phase = "reset";

  logic [2:0]  e_state;
  logic        e_en;
  logic        e_clr;
  logic        e_live;
  logic [23:0] e_disp;
  logic [23:0] cnt_val;
  logic        ticking;

  task automatic checkOutput(input string tag, input logic [2:0] st, input logic en,
                             input logic clr, input logic [23:0] disp);
    total++;
    if (bus.state !== st || bus.cnt_en !== en || bus.cnt_clr !== clr || bus.dispbuf !== disp) begin
      bad++;
      $display("[TB] FAIL %s: got state=%0d en=%0b clr=%0b disp=%06h, want state=%0d en=%0b clr=%0b disp=%06h",
               tag, bus.state, bus.cnt_en, bus.cnt_clr, bus.dispbuf, st, en, clr, disp);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the coming edge
  task automatic applyStimulus(input logic [3:0] cmd);
    exp_t e;
    @(negedge clk);
    bus.Command   = cmd;
    bus.count_bcd = cnt_val;
    step++;
    e.tag  = $sformatf("%s#%0d", phase, step);
    e.st   = e_state;
    e.en   = e_en;
    e.clr  = e_clr;
    e.disp = e_live ? cnt_val : e_disp;
    exp_q.push_back(e);
    if (ticking) cnt_val = cnt_val + 24'd1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(K_NONE);
  endtask

  // Key tap: two cycles down, then released; the action lands on the third edge
  task automatic tap(input logic [3:0] code, input logic [2:0] st, input logic en,
                     input logic clr, input logic live, input logic [23:0] disp);
    applyStimulus(code);
    applyStimulus(code);
    e_state = st;
    e_en    = en;
    e_clr   = clr;
    e_live  = live;
    e_disp  = disp;
    applyStimulus(K_NONE);
    e_clr = 1'b0;
    applyStimulus(K_NONE);
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e.tag, e.st, e.en, e.clr, e.disp);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.Command   = K_NONE;
    bus.count_bcd = 24'h0;
    cnt_val       = 24'h0;
    ticking       = 1'b0;
    e_state = S_IDLE; e_en = 1'b0; e_clr = 1'b0; e_live = 1'b1; e_disp = 24'h0;

    #12;
    checkOutput("reset_init", S_IDLE, 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start from IDLE, display follows count with one cycle lag
    phase = "ss_start";
    cnt_val = 24'h000100;
    ticking = 1'b1;
    idle(2);
    tap(K_SS, S_RUN, 1'b1, 1'b0, 1'b1, 24'h0);
    idle(3);

    // Lap capture freezes the display, a second lap re-captures
    phase = "lap";
    cnt_val = 24'h001232;
    tap(K_LAP, S_LAP, 1'b1, 1'b0, 1'b0, 24'h001234);
    idle(3);
    cnt_val = 24'h002000;
    tap(K_LAP, S_LAP, 1'b1, 1'b0, 1'b0, 24'h002002);
    idle(2);
    tap(K_SS, S_PAUSE, 1'b0, 1'b0, 1'b1, 24'h0);
    ticking = 1'b0;
    idle(2);

    // Clear from PAUSE pulses once; clear in RUN does nothing; clear in LAP releases to RUN
    phase = "clear";
    tap(K_CLR, S_IDLE, 1'b0, 1'b1, 1'b1, 24'h0);
    idle(2);
    tap(K_SS, S_RUN, 1'b1, 1'b0, 1'b1, 24'h0);
    tap(K_CLR, S_RUN, 1'b1, 1'b0, 1'b1, 24'h0);
    cnt_val = 24'h004000;
    tap(K_LAP, S_LAP, 1'b1, 1'b0, 1'b0, 24'h004000);
    tap(K_CLR, S_RUN, 1'b1, 1'b0, 1'b1, 24'h0);
    idle(2);

    // Overflow on the same edge as a start/stop press
    phase = "full";
    cnt_val = 24'h595998;
    applyStimulus(K_SS);
    applyStimulus(K_SS);
    cnt_val = FULL_VAL;
    e_state = S_FULL; e_en = 1'b0; e_live = 1'b1;
    applyStimulus(K_NONE);
    idle(2);
    cnt_val = 24'h0;
    e_live = 1'b0; e_disp = FULL_VAL;
    idle(2);
    tap(K_SS, S_FULL, 1'b0, 1'b0, 1'b0, FULL_VAL);
    tap(K_LAP, S_FULL, 1'b0, 1'b0, 1'b0, FULL_VAL);
    tap(K_CLR, S_IDLE, 1'b0, 1'b1, 1'b1, 24'h0);
    idle(2);

    // Long hold gives one press; sliding A to B gives none
    phase = "hold";
    tap(K_SS, S_RUN, 1'b1, 1'b0, 1'b1, 24'h0);
    applyStimulus(K_SS);
    applyStimulus(K_SS);
    e_state = S_PAUSE; e_en = 1'b0;
    repeat (48) applyStimulus(K_SS);
    idle(3);
    phase = "slide";
    applyStimulus(K_SS);
    applyStimulus(K_SS);
    e_state = S_RUN; e_en = 1'b1;
    applyStimulus(K_SS);
    repeat (5) applyStimulus(K_LAP);
    idle(3);

    // Asynchronous reset in the middle of a lap
    phase = "async_rst";
    cnt_val = 24'h003000;
    tap(K_LAP, S_LAP, 1'b1, 1'b0, 1'b0, 24'h003000);
    idle(2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_now", S_IDLE, 1'b0, 1'b0, 24'h0);
    @(posedge clk);
    #1;
    checkOutput("async_rst_held", S_IDLE, 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    e_state = S_IDLE; e_en = 1'b0; e_clr = 1'b0; e_live = 1'b1;
    phase = "after_rst";
    idle(3);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
